// File: rtl/video_pattern_gen.sv
// Tiled test-pattern generator: checker, bars, gradient and solid fills streamed one pixel per accept.
// Every output is a flop loaded with the value of the pixel that follows the accepting edge.
module video_pattern_gen #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned TILE_W      = 80,
  parameter int unsigned TILE_H      = 60,
  parameter int unsigned PAGE_FRAMES = 60,
  parameter int unsigned CW          = 8
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            VideoReady,
  input  logic [1:0]      Mode,
  output logic [3*CW-1:0] video,
  output logic            FrameStart,
  output logic            LineStart,
  output logic            Page,
  output logic [1:0]      ActiveMode
);

  localparam int unsigned NTX  = (H_ACTIVE + TILE_W - 1) / TILE_W;
  localparam int unsigned NTY  = (V_ACTIVE + TILE_H - 1) / TILE_H;
  localparam int unsigned XW   = (H_ACTIVE    > 1) ? $clog2(H_ACTIVE)    : 1;
  localparam int unsigned YW   = (V_ACTIVE    > 1) ? $clog2(V_ACTIVE)    : 1;
  localparam int unsigned TPXW = (TILE_W      > 1) ? $clog2(TILE_W)      : 1;
  localparam int unsigned TPYW = (TILE_H      > 1) ? $clog2(TILE_H)      : 1;
  localparam int unsigned TXW  = (NTX         > 1) ? $clog2(NTX)         : 1;
  localparam int unsigned TYW  = (NTY         > 1) ? $clog2(NTY)         : 1;
  localparam int unsigned FW   = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

  localparam logic [XW-1:0]   X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]   Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [TPXW-1:0] TPX_LAST = TPXW'(TILE_W - 1);
  localparam logic [TPYW-1:0] TPY_LAST = TPYW'(TILE_H - 1);
  localparam logic [FW-1:0]   F_LAST   = FW'(PAGE_FRAMES - 1);

  logic [XW-1:0]   x,   n_x;
  logic [YW-1:0]   y,   n_y;
  logic [TPXW-1:0] tpx, n_tpx;
  logic [TPYW-1:0] tpy, n_tpy;
  logic [TXW-1:0]  tx,  n_tx;
  logic [TYW-1:0]  ty,  n_ty;
  logic [FW-1:0]   frm, n_frm;
  logic            n_page;
  logic [1:0]      n_mode;
  logic [3*CW-1:0] n_video;
  logic [3*CW-1:0] rst_video;

  // 8-bit palette entry, left-aligned into CW bits (zero-padded or truncated).
  function automatic logic [CW-1:0] chan(input logic [7:0] c);
    return CW'({c, 24'd0} >> (32 - CW));
  endfunction

  function automatic logic [23:0] palette(input logic [2:0] p);
    logic [23:0] c;
    case (p)
      3'd0:    c = {8'd142, 8'd68,  8'd173};
      3'd1:    c = {8'd44,  8'd62,  8'd80};
      3'd2:    c = {8'd22,  8'd160, 8'd133};
      3'd3:    c = {8'd41,  8'd128, 8'd185};
      3'd4:    c = {8'd26,  8'd188, 8'd156};
      3'd5:    c = {8'd230, 8'd126, 8'd34};
      3'd6:    c = {8'd241, 8'd196, 8'd15};
      default: c = {8'd46,  8'd204, 8'd113};
    endcase
    return c;
  endfunction

  function automatic logic [3*CW-1:0] pixel(
    input logic [1:0]    md,
    input logic          pg,
    input logic          ty0,
    input logic [1:0]    tx2,
    input logic [CW-1:0] gx,
    input logic [CW-1:0] gy,
    input logic [CW-1:0] gf
  );
    logic [2:0]      p;
    logic [23:0]     c;
    logic [3*CW-1:0] v;
    p = {pg, 2'b00};
    case (md)
      2'd0:    p = {pg, ty0, tx2[0]};
      2'd1:    p = {pg, tx2};
      default: ;
    endcase
    c = palette(p);
    v = {chan(c[23:16]), chan(c[15:8]), chan(c[7:0])};
    if (md == 2'd2) v = {gx, gy, gf};
    return v;
  endfunction

  // Position after an accept: pixel/tile chain, then line/tile-row chain, then frame/page.
  always_comb begin
    n_x    = x;
    n_y    = y;
    n_tpx  = tpx;
    n_tpy  = tpy;
    n_tx   = tx;
    n_ty   = ty;
    n_frm  = frm;
    n_page = Page;
    n_mode = ActiveMode;
    if (x == X_LAST) begin
      n_x   = '0;
      n_tpx = '0;
      n_tx  = '0;
      if (y == Y_LAST) begin
        n_y    = '0;
        n_tpy  = '0;
        n_ty   = '0;
        n_mode = Mode;
        if (frm == F_LAST) begin
          n_frm  = '0;
          n_page = ~Page;
        end else begin
          n_frm = frm + FW'(1);
        end
      end else begin
        n_y = y + YW'(1);
        if (tpy == TPY_LAST) begin
          n_tpy = '0;
          n_ty  = ty + TYW'(1);
        end else begin
          n_tpy = tpy + TPYW'(1);
        end
      end
    end else begin
      n_x = x + XW'(1);
      if (tpx == TPX_LAST) begin
        n_tpx = '0;
        n_tx  = tx + TXW'(1);
      end else begin
        n_tpx = tpx + TPXW'(1);
      end
    end
  end

  always_comb begin
    n_video   = pixel(n_mode, n_page, n_ty[0], 2'(n_tx), CW'(n_x), CW'(n_y), CW'(n_frm));
    rst_video = pixel(Mode, 1'b0, 1'b0, 2'b00, '0, '0, '0);
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      x          <= '0;
      y          <= '0;
      tpx        <= '0;
      tpy        <= '0;
      tx         <= '0;
      ty         <= '0;
      frm        <= '0;
      Page       <= 1'b0;
      ActiveMode <= Mode;
      video      <= rst_video;
      FrameStart <= 1'b1;
      LineStart  <= 1'b1;
    end else if (VideoReady) begin
      x          <= n_x;
      y          <= n_y;
      tpx        <= n_tpx;
      tpy        <= n_tpy;
      tx         <= n_tx;
      ty         <= n_ty;
      frm        <= n_frm;
      Page       <= n_page;
      ActiveMode <= n_mode;
      video      <= n_video;
      FrameStart <= (n_x == '0) && (n_y == '0);
      LineStart  <= (n_x == '0);
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: two instances (16- and 18-pixel lines) against a behavioural model.
module tb_video_pattern_gen;

  localparam int H1 = 16;
  localparam int H2 = 18;
  localparam int V  = 4;
  localparam int TW = 4;
  localparam int TH = 2;
  localparam int PF = 2;

  typedef struct {
    int         x;
    int         y;
    int         frm;
    logic       page;
    logic [1:0] amode;
  } mstate_t;

  typedef struct packed {
    logic [23:0] video;
    logic        fs;
    logic        ls;
    logic        page;
    logic [1:0]  amode;
  } obs_t;

  typedef struct {
    int          pix;
    logic [23:0] video;
    logic        fs;
    logic        ls;
    logic        page;
  } vec_t;

  logic        Clock;
  logic        Reset_n;
  logic        VideoReady;
  logic [1:0]  Mode;
  logic [23:0] video_a, video_b;
  logic        fs_a, fs_b, ls_a, ls_b, page_a, page_b;
  logic [1:0]  am_a, am_b;

  int errors = 0;
  int checks = 0;
  int pix    = 0;
  mstate_t m1, m2;
  obs_t q1[$];
  obs_t q2[$];
  vec_t vecs[12];
  logic [23:0] pal[8];

  video_pattern_gen #(.H_ACTIVE(H1), .V_ACTIVE(V), .TILE_W(TW), .TILE_H(TH),
                      .PAGE_FRAMES(PF), .CW(8)) u_dut (
    .Clock(Clock), .Reset_n(Reset_n), .VideoReady(VideoReady), .Mode(Mode),
    .video(video_a), .FrameStart(fs_a), .LineStart(ls_a), .Page(page_a), .ActiveMode(am_a)
  );

  video_pattern_gen #(.H_ACTIVE(H2), .V_ACTIVE(V), .TILE_W(TW), .TILE_H(TH),
                      .PAGE_FRAMES(PF), .CW(8)) u_dut18 (
    .Clock(Clock), .Reset_n(Reset_n), .VideoReady(VideoReady), .Mode(Mode),
    .video(video_b), .FrameStart(fs_b), .LineStart(ls_b), .Page(page_b), .ActiveMode(am_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic mstate_t m_reset(input logic [1:0] md);
    mstate_t r;
    r.x = 0; r.y = 0; r.frm = 0; r.page = 1'b0; r.amode = md;
    return r;
  endfunction

  function automatic mstate_t m_adv(input mstate_t m, input int h, input logic [1:0] md);
    mstate_t r = m;
    if (r.x == h - 1) begin
      r.x = 0;
      if (r.y == V - 1) begin
        r.y = 0;
        r.amode = md;
        if (r.frm == PF - 1) begin
          r.frm = 0;
          r.page = ~r.page;
        end else r.frm++;
      end else r.y++;
    end else r.x++;
    return r;
  endfunction

  function automatic obs_t m_out(input mstate_t m);
    obs_t o;
    int tx = m.x / TW;
    int ty = m.y / TH;
    int idx = m.page ? 4 : 0;
    case (m.amode)
      2'd0:    idx += (ty % 2) * 2 + (tx % 2);
      2'd1:    idx += tx % 4;
      default: ;
    endcase
    o.video = (m.amode == 2'd2) ? {8'(m.x), 8'(m.y), 8'(m.frm)} : pal[idx];
    o.fs    = (m.x == 0) && (m.y == 0);
    o.ls    = (m.x == 0);
    o.page  = m.page;
    o.amode = m.amode;
    return o;
  endfunction

  task automatic cmp_obs(input string name, input obs_t e, input obs_t g);
    checks++;
    if (e !== g) begin
      errors++;
      $display("FAIL %s pix=%0d got video=%h fs=%b ls=%b page=%b mode=%0d, expected video=%h fs=%b ls=%b page=%b mode=%0d",
               name, pix, g.video, g.fs, g.ls, g.page, g.amode, e.video, e.fs, e.ls, e.page, e.amode);
    end
  endtask

  task automatic cmp_val(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s pix=%0d got %h expected %h", name, pix, g, e);
    end
  endtask

  // Drive one edge; the model's post-edge view is queued then matched against both DUTs.
  task automatic step(input logic rn, input logic rdy, input logic [1:0] md);
    obs_t e;
    Reset_n = rn; VideoReady = rdy; Mode = md;
    if (!rn) begin
      m1 = m_reset(md); m2 = m_reset(md); pix = 0;
    end else if (rdy) begin
      m1 = m_adv(m1, H1, md); m2 = m_adv(m2, H2, md); pix++;
    end
    q1.push_back(m_out(m1));
    q2.push_back(m_out(m2));
    @(posedge Clock);
    #1;
    e = q1.pop_front();
    cmp_obs("sb16", e, {video_a, fs_a, ls_a, page_a, am_a});
    e = q2.pop_front();
    cmp_obs("sb18", e, {video_b, fs_b, ls_b, page_b, am_b});
  endtask

  task automatic spot();
    foreach (vecs[i]) begin
      if (vecs[i].pix == pix) begin
        cmp_val($sformatf("vec%0d", i), {5'd0, video_a, fs_a, ls_a, page_a},
                {5'd0, vecs[i].video, vecs[i].fs, vecs[i].ls, vecs[i].page});
      end
    end
  endtask

  initial begin
    pal[0] = 24'h8E44AD; pal[1] = 24'h2C3E50; pal[2] = 24'h16A085; pal[3] = 24'h2980B9;
    pal[4] = 24'h1ABC9C; pal[5] = 24'hE67E22; pal[6] = 24'hF1C40F; pal[7] = 24'h2ECC71;

    vecs[0]  = '{0,   24'h8E44AD, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{3,   24'h8E44AD, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4,   24'h2C3E50, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{7,   24'h2C3E50, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8,   24'h8E44AD, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16,  24'h8E44AD, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32,  24'h16A085, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{48,  24'h16A085, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{52,  24'h2980B9, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{64,  24'h8E44AD, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{128, 24'h1ABC9C, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{129, 24'h1ABC9C, 1'b0, 1'b0, 1'b1};

    // Checker run across two frames into page 1.
    step(1'b0, 1'b1, 2'd0);
    spot();
    for (int i = 0; i < 130; i++) begin
      step(1'b1, 1'b1, 2'd0);
      spot();
    end

    // Half-rate accept: held cycles must repeat the previous pixel.
    step(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 140; i++) step(1'b1, (i % 2) == 0, 2'd0);

    // Mid-frame mode change takes effect only at the next frame.
    step(1'b0, 1'b1, 2'd0);
    while (pix < 66) begin
      step(1'b1, 1'b1, (pix >= 10) ? 2'd2 : 2'd0);
      if (pix == 63) cmp_val("mode_hold63", {8'd0, video_a}, 32'h002980B9);
      if (pix == 64) cmp_val("grad64", {8'd0, video_a}, 32'h00000001);
      if (pix == 65) cmp_val("grad65", {8'd0, video_a}, 32'h00010001);
    end

    // Reset mid-frame discards position and frame count.
    step(1'b0, 1'b1, 2'd0);
    while (pix < 37) step(1'b1, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd2);
    cmp_val("rst_mid", {video_a, fs_a, ls_a, page_a, 3'd0, am_a},
            {24'h000000, 1'b1, 1'b1, 1'b0, 3'd0, 2'd2});
    while (pix < 64) step(1'b1, 1'b1, 2'd2);
    cmp_val("rst_frm", {8'd0, video_a}, 32'h00000001);

    // Partial last tile on the 18-pixel line: tx=4 wraps bars to index 0.
    step(1'b0, 1'b1, 2'd1);
    while (pix < 20) begin
      step(1'b1, 1'b1, 2'd1);
      if (pix == 15) cmp_val("bar15", {8'd0, video_b}, 32'h002980B9);
      if (pix == 16) cmp_val("bar16", {8'd0, video_b}, 32'h008E44AD);
      if (pix == 17) cmp_val("bar17", {8'd0, video_b}, 32'h008E44AD);
      if (pix == 18) cmp_val("wrap18", {7'd0, video_b, ls_b}, {7'd0, 24'h8E44AD, 1'b1});
      if (pix == 19) cmp_val("wrap19", {8'd0, video_b}, 32'h008E44AD);
    end

    // Random accepts and mode requests, including mid-frame resets.
    step(1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
